llc_miss_ctrl: RTL

- Sequences one LLC miss through the set-buffer datapath:
  - read the set from local memory;
  - pulse the buffer load;
  - write back the dirty victim;
  - fetch the new line;
  - steer the memory response into the victim way;
  - commit the line to local memory.
- Sits between the LLC request front-end, the local-memory read/write ports, the set buffers and the memory request/response channels.
- Handles one miss at a time.

---
 rtl/llc_miss_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/llc_miss_ctrl.sv
// Sequences one LLC miss: set read, buffer load, optional dirty writeback, line fill, commit.
// Latency: 7 cycles accept-to-done with a clean or invalid victim and no stalls; a writeback adds at least 1.
// Backpressure: req_ready only while idle; memory request/response wait on mem_req_ready / mem_rsp_valid.
module llc_miss_ctrl #(
    parameter int WAY_BITS  = 4,
    parameter int TAG_BITS  = 20,
    parameter int SET_BITS  = 8,
    parameter int LINE_BITS = 128,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [TAG_BITS-1:0]          req_tag,
    input  logic [SET_BITS-1:0]          req_set,
    output logic                         lmem_rd_en,
    output logic [SET_BITS-1:0]          lmem_rd_set,
    output logic                         rd_set_into_bufs,
    input  logic [WAY_BITS-1:0]          evict_way_buf,
    input  logic                         evict_valid,
    input  logic                         evict_dirty,
    input  logic [TAG_BITS-1:0]          evict_tag,
    input  logic [LINE_BITS-1:0]         evict_line,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_hwrite,
    output logic [TAG_BITS+SET_BITS-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]         mem_req_line,
    input  logic                         mem_rsp_valid,
    output logic                         llc_mem_rsp_ready_int,
    output logic [WAY_BITS-1:0]          mem_rsp_way,
    output logic                         lmem_wr_en,
    output logic [SET_BITS-1:0]          lmem_wr_set,
    output logic [WAY_BITS-1:0]          lmem_wr_way,
    output logic                         done,
    output logic                         timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LOAD, S_EVAL, S_WB, S_FILL, S_RSP, S_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic [SET_BITS-1:0]    set_q, set_d;
    logic [WAY_BITS-1:0]    way_q, way_d;
    logic [TAG_BITS-1:0]    wb_tag_q, wb_tag_d;
    logic [LINE_BITS-1:0]   wb_line_q, wb_line_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    // Low while reset is held so req_ready stays 0 in reset; rises on the first clock after release.
    logic                   active_q;

    assign mem_rsp_way = way_q;
    assign timeout_err = err_q;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tag_q     <= '0;
            set_q     <= '0;
            way_q     <= '0;
            wb_tag_q  <= '0;
            wb_line_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            set_q     <= set_d;
            way_q     <= way_d;
            wb_tag_q  <= wb_tag_d;
            wb_line_q <= wb_line_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            active_q  <= 1'b1;
        end
    end

    // Next-state, register updates and Moore-style outputs decoded from the current state.
    always_comb begin
        state_d               = state_q;
        tag_d                 = tag_q;
        set_d                 = set_q;
        way_d                 = way_q;
        wb_tag_d              = wb_tag_q;
        wb_line_d             = wb_line_q;
        cnt_d                 = cnt_q;
        err_d                 = err_q;
        req_ready             = 1'b0;
        lmem_rd_en            = 1'b0;
        lmem_rd_set           = '0;
        rd_set_into_bufs      = 1'b0;
        mem_req_valid         = 1'b0;
        mem_req_hwrite        = 1'b0;
        mem_req_addr          = '0;
        mem_req_line          = '0;
        llc_mem_rsp_ready_int = 1'b0;
        lmem_wr_en            = 1'b0;
        lmem_wr_set           = '0;
        lmem_wr_way           = '0;
        done                  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = active_q;
                if (req_valid && active_q) begin
                    tag_d   = req_tag;
                    set_d   = req_set;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                lmem_rd_en  = 1'b1;
                lmem_rd_set = set_q;
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                rd_set_into_bufs = 1'b1;
                state_d          = S_EVAL;
            end
            S_EVAL: begin
                // Buffers now hold the set; snapshot the victim so later buffer updates cannot disturb the writeback.
                way_d = evict_way_buf;
                if (evict_valid && evict_dirty) begin
                    wb_tag_d  = evict_tag;
                    wb_line_d = evict_line;
                    state_d   = S_WB;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WB: begin
                mem_req_valid  = 1'b1;
                mem_req_hwrite = 1'b1;
                mem_req_addr   = {wb_tag_q, set_q};
                mem_req_line   = wb_line_q;
                if (mem_req_ready) state_d = S_FILL;
            end
            S_FILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, set_q};
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                llc_mem_rsp_ready_int = 1'b1;
                if (mem_rsp_valid) begin
                    state_d = S_COMMIT;
                end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                    // Flag only; the fill is still awaited indefinitely.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) err_d = 1'b1;
                end
            end
            S_COMMIT: begin
                lmem_wr_en  = 1'b1;
                lmem_wr_set = set_q;
                lmem_wr_way = way_q;
                done        = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
